// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the nibble-serial arbitrated adder: FSM encoding,
// slice width and the nibble-counter sizing helper.
package adder_arbiter_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/adder_4.sv
// 4-bit ripple-carry adder slice reused for every nibble of the serial sum.
module adder_4
    import adder_arbiter_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[NIB_W];

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one 4-bit adder slice; the WIDTH-bit sum is built
// nibble-serially (LSN first) and held until the consumer takes it.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             rsp_id,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    last_grant;
    logic [WIDTH-1:0]        a_q, b_q, sum_q;
    logic                    carry_q, id_q;
    logic                    grant_vld, grant_id;
    logic [NIB_W-1:0]        nib_sum;
    logic                    nib_cout;
    logic [WIDTH+NIB_W-1:0]  sum_shift;

    // Round-robin grant; only offered in IDLE and never while in reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld && grant_id;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = CALC;
            CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    adder_4 u_nib (
        .a    (a_q[NIB_W-1:0]),
        .b    (b_q[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // New nibble enters at the top; after NIB shifts nibble 0 sits at the bottom.
    assign sum_shift = {nib_sum, sum_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            id_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                cnt        <= '0;
                last_grant <= grant_id;
                id_q       <= grant_id;
                carry_q    <= grant_id ? req1_cin : req0_cin;
            end else if (state == CALC) begin
                cnt     <= cnt + 1'b1;
                carry_q <= nib_cout;
                sum_q   <= sum_shift[WIDTH+NIB_W-1:NIB_W];
            end
        end
    end

    // Operand shift registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            a_q <= grant_id ? req1_a : req0_a;
            b_q <= grant_id ? req1_b : req0_b;
        end else if (state == CALC) begin
            a_q <= a_q >> NIB_W;
            b_q <= b_q >> NIB_W;
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: vector table plus arbitration, backpressure,
// reset-abort and 16-bit sequences, results checked through a scoreboard.
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_cin;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_cin;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_carry, rsp_id, busy;
    logic [7:0] rsp_sum;

    logic        w_req0_valid, w_req0_ready, w_req0_cin;
    logic [15:0] w_req0_a, w_req0_b;
    logic        w_req1_valid, w_req1_ready, w_req1_cin;
    logic [15:0] w_req1_a, w_req1_b;
    logic        w_rsp_valid, w_rsp_ready, w_rsp_carry, w_rsp_id, w_busy;
    logic [15:0] w_rsp_sum;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
        .rsp_id(rsp_id), .busy(busy)
    );

    adder_arbiter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(w_req0_a), .req0_b(w_req0_b), .req0_cin(w_req0_cin),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_a(w_req1_a), .req1_b(w_req1_b), .req1_cin(w_req1_cin),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_sum(w_rsp_sum), .rsp_carry(w_rsp_carry),
        .rsp_id(w_rsp_id), .busy(w_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       id;
        logic [7:0] sum;
        logic       carry;
    } exp_t;

    typedef struct packed {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t e;
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        e.id = id;
        e.sum = t[7:0];
        e.carry = t[8];
        return e;
    endfunction

    task automatic set_req(input logic id, input logic v, input logic [7:0] a, input logic [7:0] b, input logic cin);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
        end
    endtask

    // Issues one request, pushes the expected result, checks latency.
    // Returns at the first sample where rsp_valid is high.
    task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec);
        bit   ok;
        int   lat;
        exp_t e;
        set_req(id, 1'b1, a, b, cin);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                ok = 1;
                break;
            end
        end
        check("accept_seen", 32'(ok), 1);
        if (!ok) begin
            set_req(id, 1'b0, a, b, cin);
            return;
        end
        check("other_ready_low", 32'(id ? req0_ready : req1_ready), 0);
        @(posedge clk); #1;
        // Scrambled operands after accept must not disturb the in-flight result.
        set_req(id, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        e.id = id; e.sum = es; e.carry = ec;
        sb.push_back(e);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 3);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    always @(negedge clk) begin
        check("ready_exclusive", 32'(req0_ready & req1_ready), 0);
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
                check("rsp_carry", 32'(rsp_carry), 32'(mon_e.carry));
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: time %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a0, b0, a1, b1;
        logic       cin0, cin1, acc, exp_id;
        int         got, lat;
        bit         ok;
        logic [15:0] wa[2], wb[2], ws[2];
        logic        wc[2], wco[2];

        vecs[0] = '{id: 1'b0, a: 8'h3C, b: 8'h45, cin: 1'b0, sum: 8'h81, carry: 1'b0};
        vecs[1] = '{id: 1'b0, a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, carry: 1'b0};
        vecs[2] = '{id: 1'b1, a: 8'hFF, b: 8'h00, cin: 1'b1, sum: 8'h00, carry: 1'b1};
        vecs[3] = '{id: 1'b1, a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, carry: 1'b1};
        vecs[4] = '{id: 1'b0, a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, carry: 1'b1};
        vecs[5] = '{id: 1'b1, a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, carry: 1'b0};
        vecs[6] = '{id: 1'b0, a: 8'h7F, b: 8'h7F, cin: 1'b1, sum: 8'hFF, carry: 1'b0};

        rst = 1'b1; rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 8'h11, 8'h22, 1'b0);
        set_req(1'b1, 1'b1, 8'h33, 8'h44, 1'b1);
        w_req0_valid = 0; w_req0_a = '0; w_req0_b = '0; w_req0_cin = 0;
        w_req1_valid = 0; w_req1_a = '0; w_req1_b = '0; w_req1_cin = 0;
        w_rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", 32'(req0_ready), 0);
        check("rst_ready1", 32'(req1_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_sum", 32'(rsp_sum), 0);
        check("rst_rsp_carry", 32'(rsp_carry), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        @(posedge clk); #1;

        // Vector table, single requester at a time.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].carry);
            @(posedge clk); #1;
        end

        // Round-robin with both requesters permanently valid.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255)); cin0 = 1'($urandom_range(0, 1));
        a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255)); cin1 = 1'($urandom_range(0, 1));
        set_req(1'b0, 1'b1, a0, b0, cin0);
        set_req(1'b1, 1'b1, a1, b1, cin1);
        got = 0; exp_id = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
            @(negedge clk);
            if (!(req0_ready || req1_ready)) continue;
            acc = req1_ready;
            check("rr_grant", 32'(acc), 32'(exp_id));
            exp_id = ~exp_id;
            sb.push_back(acc ? model(1'b1, a1, b1, cin1) : model(1'b0, a0, b0, cin0));
            got++;
            @(posedge clk); #1;
            if (acc) begin
                a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255)); cin1 = 1'($urandom_range(0, 1));
                set_req(1'b1, 1'b1, a1, b1, cin1);
            end else begin
                a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255)); cin0 = 1'($urandom_range(0, 1));
                set_req(1'b0, 1'b1, a0, b0, cin0);
            end
        end
        check("rr_count", 32'(got), 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        @(posedge clk); #1;

        // Backpressure: result must hold while rsp_ready is low.
        rsp_ready = 1'b0;
        do_op(1'b0, 8'h99, 8'h11, 1'b0, 8'hAA, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
        set_req(1'b1, 1'b1, 8'h03, 8'h04, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 1);
            check("bp_rsp_sum", 32'(rsp_sum), 32'h AA);
            check("bp_rsp_carry", 32'(rsp_carry), 0);
            check("bp_rsp_id", 32'(rsp_id), 0);
            check("bp_ready0", 32'(req0_ready), 0);
            check("bp_ready1", 32'(req1_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("bp_release_busy", 32'(busy), 1);
        @(negedge clk);
        check("bp_idle_busy", 32'(busy), 0);
        check("bp_idle_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;

        // Reset while an operation is in CALC.
        set_req(1'b0, 1'b1, 8'h55, 8'h66, 1'b1);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req0_ready) begin ok = 1; break; end
        end
        check("abort_accept_seen", 32'(ok), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("abort_busy_calc", 32'(busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("abort_rst_ready0", 32'(req0_ready), 0);
        check("abort_rst_ready1", 32'(req1_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_sum", 32'(rsp_sum), 0);
        check("abort_carry", 32'(rsp_carry), 0);
        check("abort_id", 32'(rsp_id), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        a0 = 8'h21; b0 = 8'h43; cin0 = 1'b0;
        set_req(1'b0, 1'b1, a0, b0, cin0);
        set_req(1'b1, 1'b1, 8'h0A, 8'h0B, 1'b0);
        @(negedge clk);
        check("abort_next_ready0", 32'(req0_ready), 1);
        check("abort_next_ready1", 32'(req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        sb.push_back(model(1'b0, a0, b0, cin0));
        wait_idle();

        // 16-bit instance: carry ripples across all four nibbles.
        wa[0] = 16'hFFFF; wb[0] = 16'h0001; wc[0] = 1'b0; ws[0] = 16'h0000; wco[0] = 1'b1;
        wa[1] = 16'h1234; wb[1] = 16'h4321; wc[1] = 1'b1; ws[1] = 16'h5556; wco[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            w_req0_valid = 1'b1; w_req0_a = wa[i]; w_req0_b = wb[i]; w_req0_cin = wc[i];
            ok = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (w_req0_ready) begin ok = 1; break; end
            end
            check("w16_accept_seen", 32'(ok), 1);
            @(posedge clk); #1;
            w_req0_valid = 1'b0; w_req0_a = 16'h0F0F; w_req0_b = 16'hF0F0;
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (w_rsp_valid) begin lat = k; break; end
            end
            check("w16_latency", 32'(lat), 5);
            check("w16_sum", 32'(w_rsp_sum), 32'(ws[i]));
            check("w16_carry", 32'(w_rsp_carry), 32'(wco[i]));
            check("w16_id", 32'(w_rsp_id), 0);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be a multiple of 4 and >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 holds an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted on this edge when valid.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req0_cin  input  1  requester 0 carry-in.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_cin  same directions, widths and meanings for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-012 rsp_carry  output  1  carry-out of the WIDTH-bit sum.
REQ-013 rsp_id  output  1  requester (0/1) the result belongs to.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL share one 4-bit ripple adder slice between two requesters, computing a WIDTH-bit sum nibble-serially, least-significant nibble first.
REQ-016 FSM states SHALL be IDLE, CALC, DONE; IDLE->CALC on accept; CALC->DONE after NIB = WIDTH/4 CALC cycles; DONE->IDLE when rsp_ready is sampled high.
REQ-017 Accept: reqN_valid && reqN_ready at a rising edge; operands, cin and grant id are latched on that edge.
REQ-018 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high in the same cycle.
REQ-019 Grant in IDLE: exactly one valid -> that requester; both valid -> requester other than last_grant (round-robin); none -> no ready.
REQ-020 last_grant SHALL update to the accepted id on each accept only.
REQ-021 reqN_ready MAY depend combinationally on req0_valid/req1_valid; it SHALL NOT depend on rsp_ready.
REQ-022 CALC cycle k (k = 0..NIB-1) SHALL add nibble k of a and b with carry = latched cin for k=0, else stored carry from cycle k-1; result nibble k stored.
REQ-023 Latency: rsp_valid SHALL first rise NIB+1 cycles after the accepting edge (3 cycles for WIDTH=8).
REQ-024 In DONE, rsp_sum, rsp_carry and rsp_id SHALL be stable and rsp_valid held high until rsp_ready is sampled high.
REQ-025 rsp_valid SHALL be low in IDLE and CALC; minimum spacing between accepts is NIB+2 cycles.
REQ-026 Request inputs changing during CALC/DONE SHALL NOT affect the in-flight result.
REQ-027 rsp_sum, rsp_carry and rsp_id outside DONE are don't-care but SHALL hold registered values (no combinational path from request inputs).

Reset
REQ-028 On rst sampled high: state=IDLE, nibble counter=0, last_grant=1 (requester 0 wins the first contested grant), rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, busy=0.
REQ-029 Reset in CALC or DONE SHALL abort the operation; no response is ever produced for it.
REQ-030 reqN_ready SHALL be low in any cycle where rst is high.

Structure
REQ-031 FSM state encoding (IDLE, CALC, DONE) and nibble width constant 4 SHALL live in the shared adder package/include.
REQ-032 The 4-bit datapath SHALL be one instance of the existing 4-bit ripple carry adder sub-module (adder_4); no other adder logic.
REQ-033 Nibble counter width SHALL be clog2(NIB), minimum 1 bit.

Verification
REQ-034 req0 only, a=0x3C b=0x45 cin=0 -> rsp_sum=0x81, rsp_carry=0, rsp_id=0, rsp_valid rises exactly 3 cycles after accept.
REQ-035 Nibble carry: a=0x0F b=0x01 cin=0 -> 0x10 carry 0; a=0xFF b=0x00 cin=1 -> 0x00 carry 1.
REQ-036 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, first grant 0; each result matches its requester's operands.
REQ-037 Backpressure: rsp_ready low 5 cycles in DONE -> rsp_valid/outputs stable, both reqN_ready low, release on 6th cycle -> IDLE next cycle.
REQ-038 rst pulse during CALC -> no rsp_valid; all outputs at reset values; next simultaneous request granted to req0.
REQ-039 WIDTH=16: a=0xFFFF b=0x0001 cin=0 -> rsp_sum=0x0000, rsp_carry=1, latency 5 cycles.
